// File: rtl/cdc_2phase_bit_deserializer.sv
// Packs the 1-bit stream leaving the clearable 2-phase CDC into WIDTH-bit words,
// LSB first, with optional trailing even parity and a double-buffered output.
module cdc_2phase_bit_deserializer #(
   parameter int WIDTH     = 8,
   parameter int PARITY_EN = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             clear_pending_i,
   input  logic             in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_par_err_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             drop_o
);

   localparam int FL = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
   localparam int CW = $clog2(FL + 1);
   localparam logic [CW-1:0] LAST = CW'(FL - 1);

   generate
      if (WIDTH < 1) begin : g_width_chk
         $error("cdc_2phase_bit_deserializer: WIDTH must be >= 1");
      end
   endgenerate

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_HOLD    = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [FL-1:0]    r_sr;
   logic [FL-1:0]    w_sr_nxt;
   logic [FL-1:0]    w_frame;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] r_or;
   logic [WIDTH-1:0] w_or_nxt;
   logic             r_perr;
   logic             w_perr_nxt;
   logic             r_oval;
   logic             w_oval_nxt;
   logic             r_drop;
   logic             w_drop_nxt;
   logic             w_acc;
   logic             w_hs;
   logic             w_frame_perr;
   logic             w_sr_perr;

   assign in_ready_o    = (r_state == S_COLLECT) & ~clear_i & ~clear_pending_i;
   assign w_acc         = in_valid_i & in_ready_o;
   assign w_hs          = r_oval & out_ready_i;
   assign out_data_o    = r_or;
   assign out_par_err_o = r_perr;
   assign out_valid_o   = r_oval;
   assign drop_o        = r_drop;

   // Incoming bit merged into its slot, so a completing frame can bypass SR.
   always_comb begin
      w_frame = r_sr;
      for (int i = 0; i < FL; i++) begin
         if (CW'(i) == r_cnt) begin
            w_frame[i] = in_data_i;
         end
      end
   end

   // XOR over data and parity bit is the even-parity mismatch flag.
   assign w_frame_perr = (PARITY_EN != 0) ? (^w_frame) : 1'b0;
   assign w_sr_perr    = (PARITY_EN != 0) ? (^r_sr) : 1'b0;

   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_cnt_nxt   = r_cnt;
      w_or_nxt    = r_or;
      w_perr_nxt  = r_perr;
      w_oval_nxt  = r_oval;
      w_drop_nxt  = 1'b0;
      if (clear_i) begin
         w_state_nxt = S_COLLECT;
         w_sr_nxt    = '0;
         w_cnt_nxt   = '0;
         w_or_nxt    = '0;
         w_perr_nxt  = 1'b0;
         w_oval_nxt  = 1'b0;
         w_drop_nxt  = (r_cnt != '0) | (r_state == S_HOLD) | r_oval;
      end else begin
         if (w_hs) begin
            w_oval_nxt = 1'b0;
         end
         unique case (r_state)
            S_COLLECT: begin
               if (clear_pending_i) begin
                  if (r_cnt != '0) begin
                     w_cnt_nxt  = '0;
                     w_sr_nxt   = '0;
                     w_drop_nxt = 1'b1;
                  end
               end else if (w_acc) begin
                  if (r_cnt == LAST) begin
                     if (!r_oval || w_hs) begin
                        w_or_nxt   = w_frame[WIDTH-1:0];
                        w_perr_nxt = w_frame_perr;
                        w_oval_nxt = 1'b1;
                        w_cnt_nxt  = '0;
                        w_sr_nxt   = '0;
                     end else begin
                        w_sr_nxt    = w_frame;
                        w_cnt_nxt   = r_cnt + CW'(1);
                        w_state_nxt = S_HOLD;
                     end
                  end else begin
                     w_sr_nxt  = w_frame;
                     w_cnt_nxt = r_cnt + CW'(1);
                  end
               end
            end
            S_HOLD: begin
               if (w_hs) begin
                  w_or_nxt    = r_sr[WIDTH-1:0];
                  w_perr_nxt  = w_sr_perr;
                  w_oval_nxt  = 1'b1;
                  w_cnt_nxt   = '0;
                  w_sr_nxt    = '0;
                  w_state_nxt = S_COLLECT;
               end
            end
            default: begin
               w_state_nxt = S_COLLECT;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_COLLECT;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_or    <= '0;
         r_perr  <= 1'b0;
         r_oval  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_or    <= w_or_nxt;
         r_perr  <= w_perr_nxt;
         r_oval  <= w_oval_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

endmodule
